// File: rtl/mc_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS control sequencer.
package mc_ctrl_pkg;

    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned STATE_W   = 4;
    localparam int unsigned ALU_OP_W  = 2;
    localparam int unsigned ALU_IMM_W = 3;
    localparam int unsigned SRC_B_W   = 2;
    localparam int unsigned PC_SRC_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SUBI  = 6'b001111;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } instr_class_t;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_IMM   = 2'b11;

    localparam logic [ALU_IMM_W-1:0] IMM_NONE = 3'b000;
    localparam logic [ALU_IMM_W-1:0] IMM_ADDI = 3'b001;
    localparam logic [ALU_IMM_W-1:0] IMM_SUBI = 3'b010;
    localparam logic [ALU_IMM_W-1:0] IMM_ANDI = 3'b011;
    localparam logic [ALU_IMM_W-1:0] IMM_ORI  = 3'b100;
    localparam logic [ALU_IMM_W-1:0] IMM_SLTI = 3'b101;

    localparam logic [SRC_B_W-1:0] SRCB_RT      = 2'b00;
    localparam logic [SRC_B_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SRC_B_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SRC_B_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [PC_SRC_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [PC_SRC_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [PC_SRC_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: instruction class, immediate ALU code and store flag.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0]  i_opcode,
    output instr_class_t         o_class,
    output logic [ALU_IMM_W-1:0] o_alu_op_imm,
    output logic                 o_is_store
);

    always_comb begin
        o_class      = CLS_ILLEGAL;
        o_alu_op_imm = IMM_NONE;
        o_is_store   = 1'b0;
        case (i_opcode)
            OP_RTYPE: o_class = CLS_RTYPE;
            OP_ADDI:  begin o_class = CLS_IMM; o_alu_op_imm = IMM_ADDI; end
            OP_SUBI:  begin o_class = CLS_IMM; o_alu_op_imm = IMM_SUBI; end
            OP_ANDI:  begin o_class = CLS_IMM; o_alu_op_imm = IMM_ANDI; end
            OP_ORI:   begin o_class = CLS_IMM; o_alu_op_imm = IMM_ORI;  end
            OP_SLTI:  begin o_class = CLS_IMM; o_alu_op_imm = IMM_SLTI; end
            OP_LW:    o_class = CLS_MEM;
            OP_SW:    begin o_class = CLS_MEM; o_is_store = 1'b1; end
            OP_BEQ:   o_class = CLS_BRANCH;
            OP_J:     o_class = CLS_JUMP;
            default:  o_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer stepping one MIPS instruction through fetch/decode/execute/memory/writeback.
module multicycle_control
    import mc_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 ir_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [SRC_B_W-1:0]   alu_src_b,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [ALU_IMM_W-1:0] alu_op_imm,
    output logic [PC_SRC_W-1:0]  pc_source,
    output logic [STATE_W-1:0]   state,
    output logic                 instr_done,
    output logic                 illegal_op
);

    state_t               r_state;
    state_t               w_next;
    instr_class_t         w_class;
    logic [ALU_IMM_W-1:0] w_alu_op_imm;
    logic                 w_is_store;

    mc_opcode_decode u_decode (
        .i_opcode     (opcode),
        .o_class      (w_class),
        .o_alu_op_imm (w_alu_op_imm),
        .o_is_store   (w_is_store)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and datapath controls; outputs depend on mem_ready only in FETCH and MEMWR.
    always_comb begin
        w_next        = r_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALU_ADD;
        alu_op_imm    = IMM_NONE;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                case (w_class)
                    CLS_RTYPE:  w_next = S_RTYPE_EX;
                    CLS_IMM:    w_next = S_IMM_EX;
                    CLS_MEM:    w_next = S_MEMADR;
                    CLS_BRANCH: w_next = S_BRANCH;
                    CLS_JUMP:   w_next = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                w_next    = w_is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_dst    = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                w_next    = S_RTYPE_WB;
            end
            S_RTYPE_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_IMM_EX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_IMM;
                alu_op_imm = w_alu_op_imm;
                w_next     = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                w_next        = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign state = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected-phase scripts plus latency/retire checks.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] alu_op_imm;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } outs_t;

    // One phase of an instruction: expected outputs when ready / while waiting, and wait length.
    typedef struct packed {
        outs_t      rdy;
        outs_t      wt;
        logic       is_wait;
        logic [3:0] nwait;
    } step_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUBI = 6'b001111;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [2:0] alu_op_imm;
    logic [3:0] state;
    logic       instr_done, illegal_op;

    int checks = 0;
    int errors = 0;
    step_t q[$];

    multicycle_control dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .alu_op_imm    (alu_op_imm),
        .pc_source     (pc_source),
        .state         (state),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic outs_t sample();
        outs_t o;
        o.state = state;           o.pc_write = pc_write;     o.pc_write_cond = pc_write_cond;
        o.ir_write = ir_write;     o.iord = iord;             o.mem_read = mem_read;
        o.mem_write = mem_write;   o.reg_write = reg_write;   o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg; o.alu_src_a = alu_src_a;   o.alu_src_b = alu_src_b;
        o.alu_op = alu_op;         o.alu_op_imm = alu_op_imm; o.pc_source = pc_source;
        o.instr_done = instr_done; o.illegal_op = illegal_op;
        return o;
    endfunction

    // Zero-wait cycles from FETCH entry to retirement; 0 marks an unsupported opcode.
    function automatic int base_lat(input logic [5:0] op);
        case (op)
            OP_J, OP_BEQ:                                       return 3;
            OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI:   return 4;
            OP_SW:                                              return 4;
            OP_LW:                                              return 5;
            default:                                            return 0;
        endcase
    endfunction

    function automatic logic [2:0] imm_code(input logic [5:0] op);
        case (op)
            OP_ADDI: return 3'b001;
            OP_SUBI: return 3'b010;
            OP_ANDI: return 3'b011;
            OP_ORI:  return 3'b100;
            OP_SLTI: return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check_outs(input string tag, input outs_t obs, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input outs_t r, input outs_t w, input logic iw, input int n);
        step_t s;
        s.rdy = r; s.wt = w; s.is_wait = iw; s.nwait = 4'(n);
        q.push_back(s);
    endtask

    // Runs one instruction from FETCH entry; fw/mw are wait cycles in FETCH and the data access.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string tag);
        outs_t o, ow;
        step_t s;
        int cyc, lat, dones, writes, ills, exp_lat;
        bit legal, is_mem, wr_reg;
        legal  = base_lat(op) != 0;
        is_mem = (op == OP_LW) || (op == OP_SW);
        wr_reg = legal && (op != OP_SW) && (op != OP_BEQ) && (op != OP_J);
        exp_lat = legal ? base_lat(op) + fw + (is_mem ? mw : 0) : 0;
        q.delete();
        o = '0; o.state = 4'd1; o.mem_read = 1'b1; o.alu_src_b = 2'b01;
        ow = o; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(o, ow, 1'b1, fw);
        o = '0; o.state = 4'd2; o.alu_src_b = 2'b11; o.illegal_op = !legal;
        push(o, o, 1'b0, 0);
        case (op)
            OP_LW, OP_SW: begin
                o = '0; o.state = 4'd3; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                push(o, o, 1'b0, 0);
                if (op == OP_LW) begin
                    o = '0; o.state = 4'd4; o.iord = 1'b1; o.mem_read = 1'b1;
                    push(o, o, 1'b1, mw);
                    o = '0; o.state = 4'd5; o.reg_dst = 1'b1; o.mem_to_reg = 1'b1;
                    o.reg_write = 1'b1; o.instr_done = 1'b1;
                    push(o, o, 1'b0, 0);
                end else begin
                    o = '0; o.state = 4'd6; o.iord = 1'b1; o.mem_write = 1'b1;
                    ow = o; o.instr_done = 1'b1;
                    push(o, ow, 1'b1, mw);
                end
            end
            OP_R: begin
                o = '0; o.state = 4'd7; o.alu_src_a = 1'b1; o.alu_op = 2'b10;
                push(o, o, 1'b0, 0);
                o = '0; o.state = 4'd8; o.reg_write = 1'b1; o.instr_done = 1'b1;
                push(o, o, 1'b0, 0);
            end
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI: begin
                o = '0; o.state = 4'd9; o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_op = 2'b11; o.alu_op_imm = imm_code(op);
                push(o, o, 1'b0, 0);
                o = '0; o.state = 4'd10; o.reg_dst = 1'b1; o.reg_write = 1'b1; o.instr_done = 1'b1;
                push(o, o, 1'b0, 0);
            end
            OP_BEQ: begin
                o = '0; o.state = 4'd11; o.alu_src_a = 1'b1; o.alu_op = 2'b01;
                o.pc_write_cond = 1'b1; o.pc_source = 2'b01; o.instr_done = 1'b1;
                push(o, o, 1'b0, 0);
            end
            OP_J: begin
                o = '0; o.state = 4'd12; o.pc_write = 1'b1; o.pc_source = 2'b10; o.instr_done = 1'b1;
                push(o, o, 1'b0, 0);
            end
            default: ;
        endcase

        opcode = op;
        cyc = 0; lat = 0; dones = 0; writes = 0; ills = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            for (int k = 0; k <= int'(s.nwait); k++) begin
                if (s.is_wait) mem_ready = (k == int'(s.nwait));
                else           mem_ready = 1'($urandom_range(0, 1));
                #1;
                cyc++;
                check_outs(tag, sample(), mem_ready ? s.rdy : s.wt);
                if (instr_done) begin dones++; lat = cyc; end
                if (reg_write)  writes++;
                if (illegal_op) ills++;
                if (instr_done && illegal_op) check_val({tag, "_done_and_illegal"}, 32'd1, 32'd0);
                @(posedge clk);
                #1;
            end
        end
        check_val({tag, "_done_count"}, 32'(dones), legal ? 32'd1 : 32'd0);
        check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_reg_writes"}, 32'(writes), wr_reg ? 32'd1 : 32'd0);
        check_val({tag, "_illegal_count"}, 32'(ills), legal ? 32'd0 : 32'd1);
    endtask

    logic [5:0] legal_ops [10];
    logic [5:0] bad_ops [5];

    initial begin
        legal_ops = '{OP_R, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J};
        bad_ops   = '{6'b111111, 6'b000001, 6'b100000, 6'b101111, 6'b000011};
        rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'b000000;

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_held", sample(), '0);
        rst_n = 1'b1;
        #1;
        check_outs("idle_after_release", sample(), '0);
        @(posedge clk);
        #1;

        run_instr(OP_ADDI, 0, 0, "addi");
        run_instr(OP_LW, 0, 2, "lw_wait2");
        run_instr(OP_R, 0, 0, "rtype_b2b");
        run_instr(OP_BEQ, 0, 0, "beq_b2b");
        run_instr(6'b111111, 0, 0, "illegal_3f");
        run_instr(OP_J, 1, 0, "j_fetchwait");

        // sw interrupted by reset while its store is still waiting
        opcode = OP_SW;
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        #1;
        check_val("sw_memwr_state", 32'(state), 32'd6);
        check_val("sw_memwr_write", 32'(mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("sw_async_reset", sample(), '0);
        @(posedge clk);
        #1;
        check_outs("sw_reset_hold", sample(), '0);
        rst_n = 1'b1;
        #1;
        check_outs("sw_reset_idle", sample(), '0);
        @(posedge clk);
        #1;
        run_instr(OP_SW, 0, 1, "sw_after_reset");

        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 4)];
            else                           op = legal_ops[$urandom_range(0, 9)];
            run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the 32-bit MIPS datapath. It replaces per-instruction single-cycle decode with a Moore FSM that steps one instruction through fetch, decode, execute, memory and writeback, sharing one memory port and one ALU across those phases. It sits beside the datapath register file, ALU and IR, takes the IR opcode plus a memory-ready handshake, and drives every datapath enable and mux select.

## Interface
- No parameters. Opcode, state and ALU codes are fixed package constants.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]. Stable from the DECODE state until the next FETCH completes.
- mem_ready  in  1  memory completes the access requested this cycle.
- pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write  out  1 each  datapath enables and selects.
- reg_dst  out  1  register destination select: 0 = rd (R-type), 1 = rt (immediate and lw).
- mem_to_reg, alu_src_a  out  1 each  writeback select and ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_op  out  2  00 = add, 01 = subtract, 10 = funct-decoded, 11 = immediate-decoded.
- alu_op_imm  out  3  001 addi, 010 subi, 011 andi, 100 ori, 101 slti, 000 otherwise.
- pc_source  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- state  out  4  current state, for debug.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  one-cycle pulse when an unsupported opcode is decoded.

## Operation
- Supported opcodes:
  - R-type 000000
  - addi 001000, subi 001111, andi 001100, ori 001101, slti 001010
  - lw 100011, sw 101011
  - beq 000100
  - j 000010
- Every output is 0 unless the state below asserts it.
- The state register is the only storage. Outputs are combinational functions of state, plus mem_ready where noted.
- IDLE (reset state): all outputs 0. Moves to FETCH on the first clock after rst_n is high.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=1 and pc_write=1 only when mem_ready=1; FETCH then moves to DECODE.
  - While mem_ready=0, the FSM holds in FETCH.
- DECODE: drives alu_src_a=0, alu_src_b=11, alu_op=00 to precompute the branch target. Next state by opcode:
  - R-type → RTYPE_EX
  - immediate ops → IMM_EX
  - lw or sw → MEMADR
  - beq → BRANCH
  - j → JUMP
  - any other opcode → FETCH, with illegal_op=1 and no register or memory write.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Moves to MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Waits for mem_ready, then moves to MEMWB.
- MEMWB: reg_dst=1, mem_to_reg=1, reg_write=1, instr_done=1. Moves to FETCH.
- MEMWR: iord=1, mem_write=1. When mem_ready=1, instr_done=1 and the FSM moves to FETCH; otherwise it holds.
- RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_op=10. Moves to RTYPE_WB.
- RTYPE_WB: reg_dst=0, reg_write=1, instr_done=1. Moves to FETCH.
- IMM_EX: alu_src_a=1, alu_src_b=10, alu_op=11, alu_op_imm set from opcode. Moves to IMM_WB.
- IMM_WB: reg_dst=1, reg_write=1, instr_done=1. Moves to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Moves to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Moves to FETCH.
- The memory-wait states are FETCH, MEMRD and MEMWR. The controller holds mem_read/mem_write steady across wait cycles and samples mem_ready every cycle. There is no timeout.

## Timing
- With zero wait states, cycles from FETCH entry to retirement:
  - j: 3
  - beq: 3
  - R-type / immediate: 4
  - sw: 4
  - lw: 5
- Each wait cycle on mem_ready adds exactly one cycle.
- rst_n low forces IDLE asynchronously at any time, including mid-access. All outputs drop to 0 in the same cycle, with no partial write or pulse.
- After rst_n rises, the first FETCH cycle is the second rising edge.
- instr_done and illegal_op never assert in the same cycle.
- At most one register write is issued per instruction.

## Structure
- Package mc_ctrl_pkg holds:
  - opcode constants
  - 4-bit state encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, RTYPE_EX 7, RTYPE_WB 8, IMM_EX 9, IMM_WB 10, BRANCH 11, JUMP 12
  - alu_op codes and alu_op_imm codes
  - alu_src_b and pc_source codes
- Sub-module mc_opcode_decode: combinational. Maps opcode to an instruction class (rtype / imm / mem / branch / jump / illegal) and to alu_op_imm. It is used by both the DECODE next-state logic and IMM_EX.

## Test plan
- Reset then addi (001000), mem_ready tied 1:
  - States IDLE, FETCH, DECODE, IMM_EX, IMM_WB.
  - alu_op_imm=001 in IMM_EX.
  - reg_write=1 with reg_dst=1 in cycle 4.
  - instr_done pulses once.
- lw (100011) with mem_ready low 2 cycles in MEMRD:
  - MEMRD lasts 3 cycles, mem_read held, iord=1.
  - Retires in 7 cycles with mem_to_reg=1.
- R-type then beq (000100) back to back:
  - RTYPE_WB has reg_dst=0.
  - BRANCH has pc_write_cond=1, pc_source=01, alu_op=01.
  - 4 + 3 cycles total.
- Opcode 111111:
  - DECODE pulses illegal_op=1, then returns to FETCH.
  - reg_write, mem_write and instr_done stay 0.
- sw (101011) with rst_n dropped while in MEMWR and mem_ready=0:
  - mem_write falls to 0 immediately and state=IDLE.
  - After release, FETCH resumes.
- j (000010) with FETCH waiting 1 cycle:
  - ir_write and pc_write assert only on the mem_ready cycle.
  - JUMP has pc_source=10; 4 cycles total.
